axis_fifo_frame_reader: RTL and testbench

- Read-side controller directly downstream of the dual-bank stream FIFO.
- Watches the FIFO `empty` flag, issues `readReq`, and accepts `readData`/`readDataValid`/`readDataLast` under `readDataReady` backpressure.
- Re-emits each frame on an AXI-Stream master port through a 2-entry skid buffer.
- Enforces a maximum frame length (truncation plus discard) and keeps frame and beat statistics.

---
 rtl/axis_fifo_frame_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_axis_fifo_frame_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_frame_reader.sv
// axis_fifo_frame_reader
//
// Read-side controller sitting directly behind the dual-bank stream FIFO.
// It waits for the FIFO to report data, requests a frame, accepts FIFO beats
// under readDataReady backpressure and re-emits them on an AXI-Stream master
// port through a 2-entry skid buffer. Frames longer than MaxBeats are cut at
// MaxBeats (the last kept beat carries tlast) and the remainder of the FIFO
// frame is drained and dropped.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              allow new frames to start (a running frame completes)
//   fifo_empty          FIFO empty flag
//   readReq             read request to the FIFO
//   readData/Valid/Last FIFO beat, handshaked with readDataReady
//   readDataReady       reader can accept a FIFO beat (registered)
//   m_axis_*            AXI-Stream master output
//   busy                FSM active or skid buffer holding data
//   frame_count         frames completed on the output (wraps)
//   trunc_count         frames truncated at MaxBeats (wraps)
//   beat_count          beats of the current frame accepted from the FIFO

module axis_fifo_frame_reader #(
  parameter int DataWidth = 32,
  parameter int MaxBeats  = 1024,
  parameter int CntWidth  = 16,
  localparam int BeatWidth = $clog2(MaxBeats + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 readReq,
  input  logic [DataWidth-1:0] readData,
  input  logic                 readDataValid,
  output logic                 readDataReady,
  input  logic                 readDataLast,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [CntWidth-1:0]  frame_count,
  output logic [CntWidth-1:0]  trunc_count,
  output logic [BeatWidth-1:0] beat_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [BeatWidth-1:0]   beat_count_reg, beat_count_next;
  logic [CntWidth-1:0]    trunc_count_reg, trunc_count_next;
  logic [CntWidth-1:0]    frame_count_reg, frame_count_next;
  logic                   ready_reg, ready_next;
  logic                   read_req_reg, read_req_next;
  logic                   busy_reg, busy_next;

  // Skid buffer: head feeds the output port, tail catches the beat that
  // arrives while the head is stalled.
  logic [DataWidth-1:0]   head_data_reg, head_data_next;
  logic                   head_last_reg, head_last_next;
  logic [DataWidth-1:0]   tail_data_reg, tail_data_next;
  logic                   tail_last_reg, tail_last_next;
  logic [1:0]             count_reg, count_next;

  logic                   reading;
  logic                   in_fire;
  logic                   out_fire;
  logic                   push;
  logic                   push_last;
  logic [BeatWidth-1:0]   beat_inc;
  logic                   at_max;

  // Beats are only taken while a frame is being read; a stray readDataValid
  // outside ACTIVE/DISCARD is ignored.
  assign reading   = (state_reg == ACTIVE) || (state_reg == DISCARD);
  assign in_fire   = readDataValid && ready_reg && reading;
  assign out_fire  = (count_reg != 2'd0) && m_axis_tready;
  assign push      = in_fire && (state_reg == ACTIVE);
  assign beat_inc  = beat_count_reg + BeatWidth'(1);
  assign at_max    = (beat_inc == BeatWidth'(MaxBeats));
  assign push_last = readDataLast || at_max;

  // Frame control
  always_comb begin
    state_next       = state_reg;
    beat_count_next  = beat_count_reg;
    trunc_count_next = trunc_count_reg;
    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_fire) begin
          beat_count_next = beat_inc;
          // A FIFO last that lands exactly on MaxBeats is a normal end.
          if (readDataLast) begin
            state_next = GAP;
          end else if (at_max) begin
            trunc_count_next = trunc_count_reg + CntWidth'(1);
            state_next       = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (in_fire && readDataLast) begin
          state_next = GAP;
        end
      end
      GAP: begin
        beat_count_next = '0;
        // GAP is the single request-free bubble between frames. The IDLE
        // start condition is evaluated here as well, so a FIFO that still
        // holds data sees exactly one cycle of readReq low.
        if (enable && !fifo_empty) begin
          state_next = ACTIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Skid buffer
  always_comb begin
    head_data_next = head_data_reg;
    head_last_next = head_last_reg;
    tail_data_next = tail_data_reg;
    tail_last_next = tail_last_reg;
    count_next     = count_reg;
    case ({push, out_fire})
      2'b10: begin
        if (count_reg == 2'd0) begin
          head_data_next = readData;
          head_last_next = push_last;
          count_next     = 2'd1;
        end else if (count_reg == 2'd1) begin
          tail_data_next = readData;
          tail_last_next = push_last;
          count_next     = 2'd2;
        end
      end
      2'b01: begin
        if (count_reg == 2'd2) begin
          head_data_next = tail_data_reg;
          head_last_next = tail_last_reg;
        end
        count_next = count_reg - 2'd1;
      end
      2'b11: begin
        // Push and pop together: occupancy unchanged, order preserved.
        if (count_reg == 2'd2) begin
          head_data_next = tail_data_reg;
          head_last_next = tail_last_reg;
          tail_data_next = readData;
          tail_last_next = push_last;
        end else begin
          head_data_next = readData;
          head_last_next = push_last;
        end
      end
      default: ;
    endcase
  end

  // Registered handshake/status outputs are computed from next-state values
  // so they line up with the state they describe.
  always_comb begin
    frame_count_next = frame_count_reg;
    if (out_fire && head_last_reg) begin
      frame_count_next = frame_count_reg + CntWidth'(1);
    end
    read_req_next = (state_next == ACTIVE) || (state_next == DISCARD);
    // Draining never pushes, so DISCARD accepts regardless of occupancy.
    ready_next    = (state_next == DISCARD) ||
                    ((state_next == ACTIVE) && (count_next <= 2'd1));
    busy_next     = (state_next != IDLE) || (count_next != 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      beat_count_reg  <= '0;
      trunc_count_reg <= '0;
      frame_count_reg <= '0;
      ready_reg       <= 1'b0;
      read_req_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      head_data_reg   <= '0;
      head_last_reg   <= 1'b0;
      tail_data_reg   <= '0;
      tail_last_reg   <= 1'b0;
      count_reg       <= 2'd0;
    end else begin
      state_reg       <= state_next;
      beat_count_reg  <= beat_count_next;
      trunc_count_reg <= trunc_count_next;
      frame_count_reg <= frame_count_next;
      ready_reg       <= ready_next;
      read_req_reg    <= read_req_next;
      busy_reg        <= busy_next;
      head_data_reg   <= head_data_next;
      head_last_reg   <= head_last_next;
      tail_data_reg   <= tail_data_next;
      tail_last_reg   <= tail_last_next;
      count_reg       <= count_next;
    end
  end

  assign readReq       = read_req_reg;
  assign readDataReady = ready_reg;
  assign m_axis_tdata  = head_data_reg;
  assign m_axis_tlast  = head_last_reg;
  assign m_axis_tvalid = (count_reg != 2'd0);
  assign busy          = busy_reg;
  assign frame_count   = frame_count_reg;
  assign trunc_count   = trunc_count_reg;
  assign beat_count    = beat_count_reg;

endmodule

// File: tb/tb_axis_fifo_frame_reader.sv
// Directed bench for axis_fifo_frame_reader (MaxBeats = 8). A queue models the
// FIFO read side; the output port is captured into a sink queue.

module tb_axis_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic        readReq;
  logic [31:0] readData;
  logic        readDataValid;
  logic        readDataReady;
  logic        readDataLast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] trunc_count;
  logic [3:0]  beat_count;

  axis_fifo_frame_reader #(
    .DataWidth(32),
    .MaxBeats (8),
    .CntWidth (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .readReq      (readReq),
    .readData     (readData),
    .readDataValid(readDataValid),
    .readDataReady(readDataReady),
    .readDataLast (readDataLast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .frame_count  (frame_count),
    .trunc_count  (trunc_count),
    .beat_count   (beat_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] src_data[$];
  logic        src_last[$];
  logic [31:0] out_data[$];
  logic        out_last[$];
  int          out_cyc[$];

  int          tready_mode = 0;  // 0: always 1, 1: toggle 1,0,..., 2: always 0
  int          phase = 0;
  int          first_in = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        chk_after_last = 1'b0;
  logic        gap_meas = 1'b0;
  int          gap_len = 0;
  int          last_gap = -1;
  logic        saw_ready_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    readDataValid = (src_data.size() != 0);
    readData      = (src_data.size() != 0) ? src_data[0] : 32'h0;
    readDataLast  = (src_data.size() != 0) ? src_last[0] : 1'b0;
    fifo_empty    = (src_data.size() == 0);
    case (tready_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = (phase % 2 == 0);
      default: m_axis_tready = 1'b0;
    endcase
    phase++;
  endtask

  task automatic load_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_data.push_back(base + 32'(i));
      src_last.push_back(i == n - 1);
    end
  endtask

  task automatic start_test();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    first_in      = -1;
    last_gap      = -1;
    gap_meas      = 1'b0;
    saw_ready_low = 1'b0;
    phase         = 0;
  endtask

  // One clock: observe at the falling edge, update the FIFO model and drive
  // new inputs just after the rising edge.
  task automatic cycle();
    logic fi, fo;
    @(negedge clk);
    fi = readDataValid && readDataReady;
    fo = m_axis_tvalid && m_axis_tready;
    if (chk_after_last) chk("gap_after_last_readReq", readReq, 1'b0);
    if (gap_meas) begin
      if (readReq) begin
        last_gap = gap_len;
        gap_meas = 1'b0;
      end else begin
        gap_len++;
      end
    end
    if (fi && readDataLast) begin
      gap_meas = 1'b1;
      gap_len  = 0;
    end
    chk_after_last = fi && readDataLast;
    if (prev_stall) begin
      chk("stall_tvalid", m_axis_tvalid, 1'b1);
      chk("stall_tdata", m_axis_tdata, prev_data);
      chk("stall_tlast", m_axis_tlast, prev_last);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (readReq && !readDataReady) saw_ready_low = 1'b1;
    if (fi && first_in < 0) first_in = cyc;
    if (fo) begin
      out_data.push_back(m_axis_tdata);
      out_last.push_back(m_axis_tlast);
      out_cyc.push_back(cyc);
      $display("[TB] cyc %0d out beat %0h last %0b", cyc, m_axis_tdata, m_axis_tlast);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fi) begin
      void'(src_data.pop_front());
      void'(src_last.pop_front());
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (!(src_data.size() == 0 && !busy) && k < 400) begin
      cycle();
      k++;
    end
    chk({tag, "_drain_done"}, (src_data.size() == 0 && !busy), 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] base, input int n);
    chk({tag, "_len"}, out_data.size(), n);
    for (int i = 0; i < n && i < out_data.size(); i++) begin
      chk({tag, "_data"}, out_data[i], base + 32'(i));
      chk({tag, "_last"}, out_last[i], (i == n - 1));
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cycle();

    // Reset state
    chk("rst_readReq", readReq, 1'b0);
    chk("rst_readDataReady", readDataReady, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_trunc_count", trunc_count, 16'd0);
    chk("rst_beat_count", beat_count, 4'd0);

    // enable low: data waiting in the FIFO, nothing starts
    start_test();
    load_frame(32'h10, 4);
    drive();
    repeat (5) cycle();
    chk("en_low_readReq", readReq, 1'b0);
    chk("en_low_busy", busy, 1'b0);
    chk("en_low_src_untouched", src_data.size(), 4);

    // Test 1: 4-beat frame, tready=1
    enable = 1'b1;
    drain("t1");
    check_frame("t1", 32'h10, 4);
    chk("t1_latency", out_cyc.size() > 0 ? out_cyc[0] : -1, first_in + 1);
    for (int i = 1; i < out_cyc.size(); i++) chk("t1_consecutive", out_cyc[i], out_cyc[0] + i);
    chk("t1_frame_count", frame_count, 16'd1);
    chk("t1_trunc_count", trunc_count, 16'd0);
    chk("t1_beat_count", beat_count, 4'd0);

    // Test 2: same frame, tready toggling 1,0,1,0
    start_test();
    tready_mode = 1;
    load_frame(32'h10, 4);
    drive();
    drain("t2");
    check_frame("t2", 32'h10, 4);
    chk("t2_ready_dropped", saw_ready_low, 1'b1);
    chk("t2_frame_count", frame_count, 16'd2);

    // Test 3: 12-beat FIFO frame truncated at 8
    start_test();
    tready_mode = 0;
    load_frame(32'h20, 12);
    drive();
    drain("t3");
    check_frame("t3", 32'h20, 8);
    chk("t3_trunc_count", trunc_count, 16'd1);
    chk("t3_frame_count", frame_count, 16'd3);
    chk("t3_beat_count", beat_count, 4'd0);

    // Test 4: 8-beat frame ending exactly at MaxBeats
    start_test();
    load_frame(32'h30, 8);
    drive();
    drain("t4");
    check_frame("t4", 32'h30, 8);
    chk("t4_trunc_count", trunc_count, 16'd1);
    chk("t4_frame_count", frame_count, 16'd4);

    // Test 5: back-to-back frames, FIFO never empty between them
    start_test();
    load_frame(32'h40, 3);
    load_frame(32'h50, 3);
    drive();
    drain("t5");
    chk("t5_len", out_data.size(), 6);
    for (int i = 0; i < 6 && i < out_data.size(); i++) begin
      chk("t5_data", out_data[i], (i < 3) ? 32'h40 + 32'(i) : 32'h50 + 32'(i - 3));
      chk("t5_last", out_last[i], (i == 2 || i == 5));
    end
    chk("t5_gap_cycles", last_gap, 1);
    chk("t5_frame_count", frame_count, 16'd6);

    // Test 6: reset with two beats buffered and tready=0
    start_test();
    tready_mode = 2;
    load_frame(32'h60, 4);
    drive();
    repeat (6) cycle();
    chk("t6_pre_tvalid", m_axis_tvalid, 1'b1);
    chk("t6_pre_tdata", m_axis_tdata, 32'h60);
    chk("t6_pre_ready_full", readDataReady, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("t6_rst_frame_count", frame_count, 16'd0);
    chk("t6_rst_trunc_count", trunc_count, 16'd0);
    chk("t6_rst_beat_count", beat_count, 4'd0);
    chk("t6_rst_readReq", readReq, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    src_data.delete();
    src_last.delete();
    prev_stall     = 1'b0;
    chk_after_last = 1'b0;
    tready_mode    = 0;
    drive();
    @(posedge clk);
    #1 reset = 1'b0;
    start_test();
    load_frame(32'h70, 4);
    drive();
    drain("t6");
    check_frame("t6", 32'h70, 4);
    chk("t6_frame_count", frame_count, 16'd1);
    chk("t6_trunc_count", trunc_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
